// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 core.
// Holds opcode constants, the fetch FSM state type and the default reset PC.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // Branch displacement: sign-extended 16-bit immediate scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
// Only the instruction's low 26 bits are needed (jump index / branch immediate).
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_low,
    input  logic        jump,
    input  logic        branch_taken,
    output logic [31:0] next_pc
);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr_low, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset(instr_low[15:0]);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the instruction for the core and counts retired instructions.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_err,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        jump,
    input  logic        branch_taken,
    output logic        fault,
    output logic [31:0] retired_count
);

    fetch_state_t state, state_next;
    logic         capture;
    logic         advance;
    logic [31:0]  next_pc;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign opcode    = instr[31:26];

    next_pc_calc u_next_pc_calc (
        .pc_plus4     (pc_plus4),
        .instr_low    (instr[25:0]),
        .jump         (jump),
        .branch_taken (branch_taken),
        .next_pc      (next_pc)
    );

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fault       = 1'b0;
        capture     = 1'b0;
        advance     = 1'b0;
        unique case (state)
            FETCH: begin
                // Request is suppressed while reset is held so a fetch never leaks out.
                imem_req = !reset;
                if (imem_err) begin
                    state_next = FAULT;
                end else if (imem_ack) begin
                    capture    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (retire) begin
                    advance    = 1'b1;
                    state_next = FETCH;
                end
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state         <= FETCH;
            pc            <= RESET_PC;
            instr         <= 32'd0;
            retired_count <= 32'd0;
        end else begin
            state <= state_next;
            if (capture) begin
                instr <= imem_rdata;
            end
            if (advance) begin
                pc            <= next_pc;
                retired_count <= retired_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences
// for multi-cycle corners, and a randomized run against a reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack, imem_err, retire, jump, branch_taken;
    logic [31:0] imem_rdata;

    logic        imem_req, instr_valid, fault;
    logic [31:0] imem_addr, instr, pc, pc_plus4, retired_count;
    logic [5:0]  opcode;

    logic        hi_req, hi_valid, hi_fault;
    logic [31:0] hi_addr, hi_instr, hi_pc, hi_pc_plus4, hi_count;
    logic [5:0]  hi_opcode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0040)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_err(imem_err), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
        .pc(pc), .pc_plus4(pc_plus4),
        .retire(retire), .jump(jump), .branch_taken(branch_taken),
        .fault(fault), .retired_count(retired_count)
    );

    fetch_unit #(.RESET_PC(32'h1000_0000)) u_hi (
        .clk(clk), .reset(reset),
        .imem_req(hi_req), .imem_addr(hi_addr),
        .imem_ack(imem_ack), .imem_err(imem_err), .imem_rdata(imem_rdata),
        .instr_valid(hi_valid), .instr(hi_instr), .opcode(hi_opcode),
        .pc(hi_pc), .pc_plus4(hi_pc_plus4),
        .retire(retire), .jump(jump), .branch_taken(branch_taken),
        .fault(hi_fault), .retired_count(hi_count)
    );

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        logic        ret;
        logic        jmp;
        logic        br;
        logic        exp_req;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic [5:0]  exp_op;
        logic [31:0] exp_count;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic e, input logic [31:0] d,
                         input logic r, input logic j, input logic b);
        imem_ack     = a;
        imem_err     = e;
        imem_rdata   = d;
        retire       = r;
        jump         = j;
        branch_taken = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference next-PC from the ISA rules, using plain signed arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic j, input logic b);
        logic [31:0] p4;
        int          off;
        p4 = p + 32'd4;
        if (j) return (p4 & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
        if (b) begin
            off = int'($signed(ins[15:0]));
            return p4 + 32'(off * 4);
        end
        return p4;
    endfunction

    logic [31:0] m_pc, m_instr, m_count;
    logic        m_valid;

    initial begin
        reset = 1'b1;
        drive(0, 0, 32'd0, 0, 0, 0);

        vecs[0]  = '{1'b1, 1'b0, 32'h8C01_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b1, 6'h23, 32'd0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 1'b0, 6'h00, 32'd1};
        vecs[2]  = '{1'b1, 1'b0, 32'h0800_0040, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0044, 1'b1, 6'h02, 32'd1};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 6'h00, 32'd2};
        vecs[4]  = '{1'b1, 1'b0, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 6'h04, 32'd2};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_00FC, 1'b0, 6'h00, 32'd3};
        vecs[6]  = '{1'b1, 1'b0, 32'h0800_0040, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_00FC, 1'b1, 6'h02, 32'd3};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 6'h00, 32'd4};
        vecs[8]  = '{1'b1, 1'b0, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 6'h04, 32'd4};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 1'b0, 6'h00, 32'd5};
        vecs[10] = '{1'b1, 1'b0, 32'h1000_FFBD, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 1'b1, 6'h04, 32'd5};
        vecs[11] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 6'h00, 32'd6};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0020, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 6'h00, 32'd6};
        vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 6'h00, 32'd7};

        // Reset state
        step();
        step();
        check("rst req",   {31'd0, imem_req}, 32'd0);
        check("rst pc",    pc, 32'h0000_0040);
        check("rst valid", {31'd0, instr_valid}, 32'd0);
        check("rst fault", {31'd0, fault}, 32'd0);
        check("rst count", retired_count, 32'd0);
        check("rst instr", instr, 32'd0);
        reset = 1'b0;
        #1;
        check("post-rst req",  {31'd0, imem_req}, 32'd1);
        check("post-rst addr", imem_addr, 32'h0000_0040);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].ack, vecs[i].err, vecs[i].rdata, vecs[i].ret, vecs[i].jmp, vecs[i].br);
            step();
            check($sformatf("vec%0d req", i),   {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            check($sformatf("vec%0d addr", i),  imem_addr, vecs[i].exp_pc);
            check($sformatf("vec%0d pc", i),    pc, vecs[i].exp_pc);
            check($sformatf("vec%0d valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d count", i), retired_count, vecs[i].exp_count);
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d opcode", i), {26'd0, opcode}, {26'd0, vecs[i].exp_op});
        end

        // Slow memory: no ack for 3 cycles, retire pulses during FETCH are ignored
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'hDEAD_BEEF, 1, 1, 1);
            step();
            check($sformatf("wait%0d req", i),   {31'd0, imem_req}, 32'd1);
            check($sformatf("wait%0d addr", i),  imem_addr, 32'h0000_0000);
            check($sformatf("wait%0d valid", i), {31'd0, instr_valid}, 32'd0);
            check($sformatf("wait%0d count", i), retired_count, 32'd7);
        end
        drive(1, 0, 32'h2001_0005, 0, 0, 0);
        step();
        check("slow ack valid",  {31'd0, instr_valid}, 32'd1);
        check("slow ack opcode", {26'd0, opcode}, 32'h0000_0008);
        check("slow ack req",    {31'd0, imem_req}, 32'd0);

        // Randomized run against the reference model
        m_pc    = 32'h0000_0000;
        m_instr = 32'h2001_0005;
        m_valid = 1'b1;
        m_count = 32'd7;
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom % 2), 1'b0, $urandom, 1'($urandom % 2),
                  1'($urandom % 2), 1'($urandom % 2));
            @(posedge clk);
            if (!m_valid) begin
                if (imem_ack) begin
                    m_instr = imem_rdata;
                    m_valid = 1'b1;
                end
            end else if (retire) begin
                m_pc    = ref_next(m_pc, m_instr, jump, branch_taken);
                m_valid = 1'b0;
                m_count = m_count + 32'd1;
            end
            #1;
            check("rnd req",   {31'd0, imem_req}, {31'd0, !m_valid});
            check("rnd addr",  imem_addr, m_pc);
            check("rnd pc4",   pc_plus4, m_pc + 32'd4);
            check("rnd valid", {31'd0, instr_valid}, {31'd0, m_valid});
            check("rnd count", retired_count, m_count);
            check("rnd fault", {31'd0, fault}, 32'd0);
            if (m_valid) check("rnd instr", instr, m_instr);
        end
        drive(0, 0, 32'd0, 0, 0, 0);

        // Jump beats branch; upper PC nibble comes from pc_plus4
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("hi rst addr", hi_addr, 32'h1000_0000);
        drive(1, 0, 32'h0800_0010, 0, 0, 0);
        step();
        check("hi opcode", {26'd0, hi_opcode}, 32'h0000_0002);
        drive(0, 0, 32'd0, 1, 1, 1);
        step();
        check("hi jump addr",   hi_addr, 32'h1000_0040);
        check("hi jump req",    {31'd0, hi_req}, 32'd1);
        check("lo jump addr",   imem_addr, 32'h0000_0040);
        check("lo jump count",  retired_count, 32'd1);

        // Error with simultaneous ack -> sticky fault
        drive(1, 1, 32'h8C01_0004, 0, 0, 0);
        step();
        check("err fault", {31'd0, fault}, 32'd1);
        check("err req",   {31'd0, imem_req}, 32'd0);
        check("err valid", {31'd0, instr_valid}, 32'd0);
        drive(1, 0, 32'h8C01_0004, 1, 0, 0);
        step();
        check("fault stays", {31'd0, fault}, 32'd1);
        check("fault req",   {31'd0, imem_req}, 32'd0);
        check("fault valid", {31'd0, instr_valid}, 32'd0);
        check("fault count", retired_count, 32'd1);
        check("fault pc",    pc, 32'h0000_0040);

        // Asynchronous reset between clock edges clears the fault
        drive(0, 0, 32'd0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async fault", {31'd0, fault}, 32'd0);
        check("async pc",    pc, 32'h0000_0040);
        check("async req",   {31'd0, imem_req}, 32'd0);
        check("async count", retired_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("restart req",  {31'd0, imem_req}, 32'd1);
        check("restart addr", imem_addr, 32'h0000_0040);
        drive(1, 0, 32'hAC22_0008, 0, 0, 0);
        step();
        check("restart valid",  {31'd0, instr_valid}, 32'd1);
        check("restart opcode", {26'd0, opcode}, 32'h0000_002B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
